// File: rtl/stb_param_buffer_pkg.sv
// stb_pkg: shared types for the store buffer.
//   stb_entry_t   - one buffered store {addr, data, sel}
//   drain_state_t - drain FSM states
//   STB_PTR_W()   - pointer width (index bits + wrap bit) for a given depth
// Entry field widths are fixed here. The top-level ADDR_W/DATA_W parameters
// must match STB_ADDR_W/STB_DATA_W.
package stb_pkg;
  localparam int STB_ADDR_W = 32;
  localparam int STB_DATA_W = 32;
  localparam int STB_SEL_W  = STB_DATA_W / 8;

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    logic [STB_SEL_W-1:0]  sel;
  } stb_entry_t;

  typedef enum logic {DRAIN_IDLE, DRAIN_REQ} drain_state_t;

  function automatic int STB_PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/stb_param_buffer_if.sv
// stb_param_buffer_if: LSU-side, dcache-side and status signals of the store buffer.
//   slave  modport - the buffer itself
//   master modport - the LSU / dcache environment driving it
interface stb_param_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // LSU side
  logic              dmem_sel_i;
  logic              lsudbus2stb_req;
  logic              lsudbus2stb_w_en;
  logic [ADDR_W-1:0] lsudbus2stb_addr;
  logic [DATA_W-1:0] lsudbus2stb_wdata;
  logic [SEL_W-1:0]  lsudbus2stb_sel;
  logic              stb2dbuslsu_ack;
  logic              stb_stall;
  logic              stb2lsu_fwd_hit;
  logic [DATA_W-1:0] stb2lsu_fwd_data;
  logic              stb2lsu_fwd_stall;
  // dcache side
  logic              stb2dcache_req;
  logic [ADDR_W-1:0] stb2dcache_addr;
  logic [DATA_W-1:0] stb2dcache_wdata;
  logic [SEL_W-1:0]  stb2dcache_sel;
  logic              dcache2stb_ack;
  // status
  logic              stb_empty;
  logic              stb_full;
  logic [CNT_W-1:0]  stb_count;

  modport slave (
    input  dmem_sel_i, lsudbus2stb_req, lsudbus2stb_w_en, lsudbus2stb_addr,
           lsudbus2stb_wdata, lsudbus2stb_sel, dcache2stb_ack,
    output stb2dbuslsu_ack, stb_stall, stb2lsu_fwd_hit, stb2lsu_fwd_data,
           stb2lsu_fwd_stall, stb2dcache_req, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel, stb_empty, stb_full, stb_count
  );

  modport master (
    output dmem_sel_i, lsudbus2stb_req, lsudbus2stb_w_en, lsudbus2stb_addr,
           lsudbus2stb_wdata, lsudbus2stb_sel, dcache2stb_ack,
    input  stb2dbuslsu_ack, stb_stall, stb2lsu_fwd_hit, stb2lsu_fwd_data,
           stb2lsu_fwd_stall, stb2dcache_req, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel, stb_empty, stb_full, stb_count
  );
endinterface

// File: rtl/stb_param_buffer_fwd_lookup.sv
// stb_fwd_lookup: combinational store-to-load forwarding search.
//   entries_i/valid_i - buffer contents and per-slot valid bits
//   rd_idx_i          - slot of the oldest entry
//   load_i, addr_i    - load presented this cycle and its address
//   hit_o/data_o      - youngest matching store covers the whole word
//   stall_o           - youngest matching store is partial
module stb_fwd_lookup import stb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = STB_ADDR_W,
  parameter int DATA_W = STB_DATA_W
) (
  input  stb_entry_t [DEPTH-1:0]       entries_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx_i,
  input  logic                         load_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o,
  output logic                         stall_o
);
  localparam int IW  = $clog2(DEPTH);
  localparam int OFF = $clog2(DATA_W / 8);

  logic          found;
  logic [IW-1:0] idx;
  logic [IW-1:0] yidx;

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    yidx    = '0;
    hit_o   = 1'b0;
    data_o  = '0;
    stall_o = 1'b0;
    // Walk oldest to youngest so the last match seen is the youngest one.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx_i + IW'(k);
      if (valid_i[idx] && entries_i[idx].addr[ADDR_W-1:OFF] == addr_i[ADDR_W-1:OFF]) begin
        found = 1'b1;
        yidx  = idx;
      end
    end
    if (load_i && found) begin
      if (&entries_i[yidx].sel) begin
        hit_o  = 1'b1;
        data_o = entries_i[yidx].data;
      end else begin
        stall_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stb_param_buffer.sv
// stb_param_buffer: DEPTH-entry posted-store FIFO between the LSU and the dcache.
//   clk, rst_n - clock, async active-low reset
//   bus        - stb_param_buffer_if.slave (LSU request/ack/stall, dcache drain
//                handshake, occupancy flags, forwarding outputs)
// Enqueue and drain run concurrently. The drain FSM presents the head entry
// until dcache2stb_ack.
// Optional feature macro STB_FWD_EN: builds store-to-load forwarding.
// Without it, the forwarding outputs are tied to 0.
module stb_param_buffer import stb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = STB_ADDR_W,
  parameter int DATA_W = STB_DATA_W
) (
  input logic          clk,
  input logic          rst_n,
  stb_param_buffer_if.slave bus
);
  localparam int PW = STB_PTR_W(DEPTH);
  localparam int IW = PW - 1;

  stb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count, count_d;
  drain_state_t  state_q, state_d;
  logic          ack_q, store_valid, push, pop, empty, full, req;
  stb_entry_t    head;

  assign store_valid = bus.dmem_sel_i & bus.lsudbus2stb_req & bus.lsudbus2stb_w_en;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  // A pop in the same cycle does not free a slot for the current store.
  assign push  = store_valid & ~full;
  assign req   = (state_q == DRAIN_REQ);
  assign pop   = req & bus.dcache2stb_ack;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = wr_ptr_d - rd_ptr_d;

  // The next-cycle occupancy drives the transitions. This lets a push into an
  // empty buffer raise req in the very next cycle. It also lets the FSM stay
  // in DRAIN_REQ across back-to-back pops without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE: if (count_d != '0) state_d = DRAIN_REQ;
      DRAIN_REQ:  if (count_d == '0) state_d = DRAIN_IDLE;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= DRAIN_IDLE;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      ack_q    <= push;
    end
  end

  // Entry storage needs no reset. The pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[IW-1:0]].addr <= bus.lsudbus2stb_addr;
      mem_q[wr_ptr_q[IW-1:0]].data <= bus.lsudbus2stb_wdata;
      mem_q[wr_ptr_q[IW-1:0]].sel  <= bus.lsudbus2stb_sel;
    end
  end

  assign head = mem_q[rd_ptr_q[IW-1:0]];

  assign bus.stb2dbuslsu_ack  = ack_q;
  assign bus.stb_stall        = store_valid & full;
  assign bus.stb2dcache_req   = req;
  assign bus.stb2dcache_addr  = req ? head.addr : '0;
  assign bus.stb2dcache_wdata = req ? head.data : '0;
  assign bus.stb2dcache_sel   = req ? head.sel  : '0;
  assign bus.stb_empty        = empty;
  assign bus.stb_full         = full;
  assign bus.stb_count        = count;

`ifdef STB_FWD_EN
  logic [DEPTH-1:0] valid;
  logic             load_valid;
  logic [IW-1:0]    age [DEPTH];

  assign load_valid = bus.dmem_sel_i & bus.lsudbus2stb_req & ~bus.lsudbus2stb_w_en;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i]   = IW'(i) - rd_ptr_q[IW-1:0];
      valid[i] = ({1'b0, age[i]} < count);
    end
  end

  stb_fwd_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
    .entries_i (mem_q),
    .valid_i   (valid),
    .rd_idx_i  (rd_ptr_q[IW-1:0]),
    .load_i    (load_valid),
    .addr_i    (bus.lsudbus2stb_addr),
    .hit_o     (bus.stb2lsu_fwd_hit),
    .data_o    (bus.stb2lsu_fwd_data),
    .stall_o   (bus.stb2lsu_fwd_stall)
  );
`else
  assign bus.stb2lsu_fwd_hit   = 1'b0;
  assign bus.stb2lsu_fwd_data  = '0;
  assign bus.stb2lsu_fwd_stall = 1'b0;
`endif
endmodule

// File: tb/tb_stb_param_buffer.sv
// Self-checking bench for stb_param_buffer. It uses a constant-expectation vector
// table plus hand sequences and random traffic, all checked against a queue model.
module tb_stb_param_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stb_param_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus();

  stb_param_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        sv, rq, wen;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        dack;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_ack, e_stall, e_req;
    int          e_cnt;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] a, d;
    logic [3:0]  s;
  } ment_t;

  ment_t mq[$];
  bit    m_ack;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, act, exp, $time);
    end
  endtask

  function automatic in_t st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic dack);
    in_t v;
    v.sv = 1; v.rq = 1; v.wen = 1; v.a = a; v.d = d; v.s = s; v.dack = dack;
    return v;
  endfunction

  function automatic in_t ld(input logic [31:0] a, input logic dack);
    in_t v;
    v.sv = 1; v.rq = 1; v.wen = 0; v.a = a; v.d = 32'h0; v.s = 4'h0; v.dack = dack;
    return v;
  endfunction

  function automatic in_t idle(input logic dack);
    in_t v;
    v.sv = 0; v.rq = 0; v.wen = 0; v.a = 32'h0; v.d = 32'h0; v.s = 4'h0; v.dack = dack;
    return v;
  endfunction

  task automatic apply(input in_t v);
    bus.dmem_sel_i        = v.sv;
    bus.lsudbus2stb_req   = v.rq;
    bus.lsudbus2stb_w_en  = v.wen;
    bus.lsudbus2stb_addr  = v.a;
    bus.lsudbus2stb_wdata = v.d;
    bus.lsudbus2stb_sel   = v.s;
    bus.dcache2stb_ack    = v.dack;
  endtask

  // Expected outputs follow directly from the model queue contents.
  task automatic model_check(input in_t v);
    int n;
    bit store_v, load_v, found;
    logic hit, fs;
    logic [31:0] fd;
    n = mq.size();
    store_v = v.sv & v.rq & v.wen;
    load_v  = v.sv & v.rq & ~v.wen;
    chk("ack",   bus.stb2dbuslsu_ack, m_ack);
    chk("stall", bus.stb_stall, store_v && n == DEPTH);
    chk("req",   bus.stb2dcache_req, n > 0);
    chk("addr",  bus.stb2dcache_addr,  n > 0 ? mq[0].a : 32'h0);
    chk("wdata", bus.stb2dcache_wdata, n > 0 ? mq[0].d : 32'h0);
    chk("sel",   bus.stb2dcache_sel,   n > 0 ? mq[0].s : 4'h0);
    chk("empty", bus.stb_empty, n == 0);
    chk("full",  bus.stb_full, n == DEPTH);
    chk("count", bus.stb_count, n);
    hit = 0; fs = 0; fd = 0; found = 0;
    if (load_v) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && mq[i].a[31:2] == v.a[31:2]) begin
          found = 1;
          if (mq[i].s == 4'hF) begin hit = 1; fd = mq[i].d; end
          else fs = 1;
        end
      end
    end
`ifndef STB_FWD_EN
    hit = 0; fs = 0; fd = 0;
`endif
    chk("fwd_hit",   bus.stb2lsu_fwd_hit, hit);
    chk("fwd_data",  bus.stb2lsu_fwd_data, fd);
    chk("fwd_stall", bus.stb2lsu_fwd_stall, fs);
  endtask

  task automatic model_update(input in_t v);
    bit push, pop;
    push = v.sv & v.rq & v.wen & (mq.size() < DEPTH);
    pop  = (mq.size() > 0) & v.dack;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{a: v.a, d: v.d, s: v.s});
    m_ack = push;
  endtask

  task automatic cyc_pre(input in_t v);
    apply(v);
    @(negedge clk);
    model_check(v);
  endtask

  task automatic cyc_post(input in_t v);
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  task automatic cyc(input in_t v);
    cyc_pre(v);
    cyc_post(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req",   bus.stb2dcache_req, 1'b0);
    chk("rst_empty", bus.stb_empty, 1'b1);
    chk("rst_count", bus.stb_count, 0);
    chk("rst_ack",   bus.stb2dbuslsu_ack, 1'b0);
    mq.delete();
    m_ack = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit store, input logic [31:0] a, input logic dack,
                              input logic ack, input logic stall, input logic req,
                              input int cnt, input logic [31:0] ea);
    vec_t r;
    r.i = store ? st(a, a ^ 32'hA5A5_0000, 4'hF, dack) : idle(dack);
    r.e_ack = ack; r.e_stall = stall; r.e_req = req; r.e_cnt = cnt; r.e_addr = ea;
    return r;
  endfunction

  vec_t tbl[21];

  initial begin
    in_t v;
    logic e_hit, e_fs;
    logic [31:0] e_fd;

    // fill, hold-while-stalled, push+pop at full and at count 2, then drain
    tbl[0]  = mk(1, 32'h10, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h20, 0, 1, 0, 1, 1, 32'h10);
    tbl[2]  = mk(1, 32'h30, 0, 1, 0, 1, 2, 32'h10);
    tbl[3]  = mk(1, 32'h40, 0, 1, 0, 1, 3, 32'h10);
    tbl[4]  = mk(1, 32'h50, 0, 1, 1, 1, 4, 32'h10);
    tbl[5]  = mk(1, 32'h50, 0, 0, 1, 1, 4, 32'h10);
    tbl[6]  = mk(1, 32'h50, 1, 0, 1, 1, 4, 32'h10);
    tbl[7]  = mk(1, 32'h50, 0, 0, 0, 1, 3, 32'h20);
    tbl[8]  = mk(0, 32'h0,  0, 1, 0, 1, 4, 32'h20);
    tbl[9]  = mk(0, 32'h0,  1, 0, 0, 1, 4, 32'h20);
    tbl[10] = mk(0, 32'h0,  0, 0, 0, 1, 3, 32'h30);
    tbl[11] = mk(0, 32'h0,  1, 0, 0, 1, 3, 32'h30);
    tbl[12] = mk(0, 32'h0,  1, 0, 0, 1, 2, 32'h40);
    tbl[13] = mk(0, 32'h0,  1, 0, 0, 1, 1, 32'h50);
    tbl[14] = mk(1, 32'h60, 0, 0, 0, 0, 0, 32'h0);
    tbl[15] = mk(1, 32'h70, 0, 1, 0, 1, 1, 32'h60);
    tbl[16] = mk(1, 32'h80, 1, 1, 0, 1, 2, 32'h60);
    tbl[17] = mk(0, 32'h0,  0, 1, 0, 1, 2, 32'h70);
    tbl[18] = mk(0, 32'h0,  1, 0, 0, 1, 2, 32'h70);
    tbl[19] = mk(0, 32'h0,  1, 0, 0, 1, 1, 32'h80);
    tbl[20] = mk(0, 32'h0,  0, 0, 0, 0, 0, 32'h0);

    m_ack = 0;
    apply(idle(0));
    repeat (2) @(posedge clk);
    #1;
    model_check(idle(0));   // reset state
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      cyc_pre(tbl[k].i);
      chk($sformatf("tbl%0d_ack", k),   bus.stb2dbuslsu_ack, tbl[k].e_ack);
      chk($sformatf("tbl%0d_stall", k), bus.stb_stall, tbl[k].e_stall);
      chk($sformatf("tbl%0d_req", k),   bus.stb2dcache_req, tbl[k].e_req);
      chk($sformatf("tbl%0d_count", k), bus.stb_count, tbl[k].e_cnt);
      chk($sformatf("tbl%0d_addr", k),  bus.stb2dcache_addr, tbl[k].e_addr);
      chk($sformatf("tbl%0d_full", k),  bus.stb_full, tbl[k].e_cnt == DEPTH);
      cyc_post(tbl[k].i);
    end

    // drain order with an ack pulse every third cycle
    for (int k = 0; k < 4; k++) cyc(st(32'hA00 + 32'(k * 4), 32'hD0 + 32'(k), 4'hF, 0));
    for (int c = 0; c < 14; c++) cyc(idle(c % 3 == 2));
    chk("drain_empty", bus.stb_empty, 1'b1);

    // forwarding: youngest full-word store wins; partial store forces stall
`ifdef STB_FWD_EN
    e_hit = 1; e_fd = 32'h2222_2222; e_fs = 1;
`else
    e_hit = 0; e_fd = 32'h0; e_fs = 0;
`endif
    do_reset();
    cyc(st(32'h100, 32'h1111_1111, 4'hF, 0));
    cyc(st(32'h100, 32'h2222_2222, 4'hF, 0));
    v = ld(32'h100, 0);
    cyc_pre(v);
    chk("fwd_hit_full", bus.stb2lsu_fwd_hit, e_hit);
    chk("fwd_data_full", bus.stb2lsu_fwd_data, e_fd);
    chk("fwd_stall_full", bus.stb2lsu_fwd_stall, 1'b0);
    cyc_post(v);
    cyc(st(32'h200, 32'h3333_3333, 4'h3, 0));
    v = ld(32'h200, 0);
    cyc_pre(v);
    chk("fwd_stall_part", bus.stb2lsu_fwd_stall, e_fs);
    chk("fwd_hit_part", bus.stb2lsu_fwd_hit, 1'b0);
    cyc_post(v);
    cyc(ld(32'h300, 0));

    // reset while draining with three entries queued
    do_reset();
    for (int k = 0; k < 3; k++) cyc(st(32'hC00 + 32'(k * 4), 32'hE0 + 32'(k), 4'hF, 0));
    chk("pre_rst_count", bus.stb_count, 3);
    do_reset();
    cyc(st(32'h400, 32'h4444_4444, 4'hF, 0));
    cyc(idle(0));
    chk("post_rst_addr", bus.stb2dcache_addr, 32'h400);
    cyc(idle(1));
    cyc(idle(0));

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = 32'h100 + 32'($urandom_range(0, 3) * 4);
      if (kind < 5) v = st(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                           $urandom_range(0, 2) == 0);
      else if (kind < 8) v = ld(a + 32'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      else v = idle($urandom_range(0, 2) == 0);
      v.sv = ($urandom_range(0, 7) != 0);
      cyc(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
